// File: rtl/perf_counter_ctrl.sv
// Bank of hold-qualified event counters with a shared valid/ready read / read-and-clear port.
// Optional build macro PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_counter_ctrl #(
    parameter int NUM_CTR = 8,
    parameter int WIDTH   = 16,
    parameter int HOLD    = 2,
    localparam int AW     = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_CTR-1:0] event_i,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_clear,
    input  logic [AW-1:0]      req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               rsp_ovf
);

    localparam int              KW        = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [KW-1:0]   HOLD_K    = KW'(HOLD);
    localparam logic [AW:0]     NUM_CTR_W = (AW + 1)'(NUM_CTR);
    localparam logic [WIDTH-1:0] CTR_MAX  = '1;

    localparam logic [1:0] Q_IDLE    = 2'd0;
    localparam logic [1:0] Q_HOLDING = 2'd1;
    localparam logic [1:0] Q_LOCKED  = 2'd2;

    localparam logic A_IDLE = 1'b0;
    localparam logic A_RESP = 1'b1;

    logic [1:0]         qst_q [NUM_CTR];
    logic [1:0]         qst_d [NUM_CTR];
    logic [KW-1:0]      k_q   [NUM_CTR];
    logic [KW-1:0]      k_d   [NUM_CTR];
    logic [WIDTH-1:0]   ctr_q [NUM_CTR];
    logic [WIDTH-1:0]   ctr_d [NUM_CTR];
    logic [NUM_CTR-1:0] ovf_q, ovf_d;
    logic [NUM_CTR-1:0] inc;
    logic [NUM_CTR-1:0] clr_hit;

    logic               acc_q, acc_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_ovf_q, rsp_ovf_d;

    logic               hs;
    logic               addr_ok;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_ovf;

    // One qualifier per channel: an event counts once per sustained assertion of HOLD+1 cycles.
    always_comb begin
        for (int i = 0; i < NUM_CTR; i++) begin
            qst_d[i] = qst_q[i];
            k_d[i]   = k_q[i];
            inc[i]   = 1'b0;
            case (qst_q[i])
                Q_IDLE: begin
                    if (event_i[i]) begin
                        if (HOLD == 0) begin
                            inc[i]   = 1'b1;
                            qst_d[i] = Q_LOCKED;
                        end else begin
                            qst_d[i] = Q_HOLDING;
                            k_d[i]   = KW'(1);
                        end
                    end
                end
                Q_HOLDING: begin
                    if (!event_i[i]) begin
                        qst_d[i] = Q_IDLE;
                    end else if (k_q[i] == HOLD_K) begin
                        inc[i]   = 1'b1;
                        qst_d[i] = Q_LOCKED;
                    end else begin
                        k_d[i] = k_q[i] + KW'(1);
                    end
                end
                Q_LOCKED: begin
                    if (!event_i[i]) qst_d[i] = Q_IDLE;
                end
                default: qst_d[i] = Q_IDLE;
            endcase
        end
    end

    assign hs      = req_valid && (acc_q == A_IDLE);
    assign addr_ok = ({1'b0, req_addr} < NUM_CTR_W);

    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        clr_hit  = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (req_addr == AW'(i)) begin
                sel_data   = ctr_q[i];
                sel_ovf    = ovf_q[i];
                clr_hit[i] = hs && req_clear;
            end
        end
    end

    // A clear in the handshake cycle wins over a same-cycle qualified increment.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CTR; i++) begin
            ctr_d[i] = ctr_q[i];
            if (clr_hit[i]) begin
                ctr_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc[i]) begin
`ifdef PERF_SATURATE_EN
                if (ctr_q[i] == CTR_MAX) ovf_d[i] = 1'b1;
                else                     ctr_d[i] = ctr_q[i] + WIDTH'(1);
`else
                ctr_d[i] = ctr_q[i] + WIDTH'(1);
                if (ctr_q[i] == CTR_MAX) ovf_d[i] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_ovf_d  = rsp_ovf_q;
        case (acc_q)
            A_IDLE: begin
                if (req_valid) begin
                    acc_d      = A_RESP;
                    rsp_err_d  = !addr_ok;
                    rsp_data_d = addr_ok ? sel_data : '0;
                    rsp_ovf_d  = addr_ok && sel_ovf;
                end
            end
            A_RESP: begin
                if (rsp_ready) acc_d = A_IDLE;
            end
            default: acc_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                qst_q[i] <= Q_IDLE;
                k_q[i]   <= '0;
                ctr_q[i] <= '0;
            end
            ovf_q      <= '0;
            acc_q      <= A_IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                qst_q[i] <= qst_d[i];
                k_q[i]   <= k_d[i];
                ctr_q[i] <= ctr_d[i];
            end
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign req_ready = (acc_q == A_IDLE);
    assign rsp_valid = (acc_q == A_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Bench for perf_counter_ctrl: a default instance (8 x 16 bit, HOLD=2) and a small one
// (6 x 4 bit, HOLD=0) that reaches wrap and out-of-range addresses in few cycles.
module tb_perf_counter_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic [7:0]  event_i;
    logic        req_valid, req_ready, req_clear;
    logic [2:0]  req_addr;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err, rsp_ovf;

    logic [5:0]  s_event;
    logic        s_req_valid, s_req_ready, s_req_clear;
    logic [2:0]  s_req_addr;
    logic        s_rsp_valid, s_rsp_ready;
    logic [3:0]  s_rsp_data;
    logic        s_rsp_err, s_rsp_ovf;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    logic [5:0]  exp_s_q[$];
    logic [17:0] m_exp;
    logic [5:0]  m_exp_s;

`ifdef PERF_SATURATE_EN
    localparam logic [3:0] S_AFTER_WRAP = 4'hF;
`else
    localparam logic [3:0] S_AFTER_WRAP = 4'h0;
`endif

    perf_counter_ctrl #(.NUM_CTR(8), .WIDTH(16), .HOLD(2)) dut (
        .clk(clk), .reset(reset), .event_i(event_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_clear(req_clear), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ovf(rsp_ovf)
    );

    perf_counter_ctrl #(.NUM_CTR(6), .WIDTH(4), .HOLD(0)) dut_small (
        .clk(clk), .reset(reset), .event_i(s_event),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_clear(s_req_clear), .req_addr(s_req_addr),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .rsp_err(s_rsp_err), .rsp_ovf(s_rsp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever a response is accepted.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main_unexpected_rsp: got 0x%0h expected none", rsp_data);
            end else begin
                m_exp = exp_q.pop_front();
                check("main_rsp {err,ovf,data}", {14'd0, rsp_err, rsp_ovf, rsp_data}, {14'd0, m_exp});
            end
        end
        if (s_rsp_valid && s_rsp_ready) begin
            if (exp_s_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL small_unexpected_rsp: got 0x%0h expected none", s_rsp_data);
            end else begin
                m_exp_s = exp_s_q.pop_front();
                check("small_rsp {err,ovf,data}", {26'd0, s_rsp_err, s_rsp_ovf, s_rsp_data}, {26'd0, m_exp_s});
            end
        end
    end

    // Drivers assume they are entered just after a rising edge.
    task automatic pulse(input int ch, input int len);
        event_i[ch] = 1'b1;
        repeat (len) begin @(posedge clk); #1; end
        event_i[ch] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic s_pulse(input int ch, input int len);
        s_event[ch] = 1'b1;
        repeat (len) begin @(posedge clk); #1; end
        s_event[ch] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic [2:0] addr, input logic clr, input logic [15:0] d,
                          input logic e, input logic o);
        int n = 0;
        req_valid = 1'b1; req_addr = addr; req_clear = clr;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL main_req_timeout: got req_ready=0 expected 1");
            req_valid = 1'b0; req_clear = 1'b0;
            return;
        end
        exp_q.push_back({e, o, d});
        @(posedge clk); #1;
        req_valid = 1'b0; req_clear = 1'b0;
        check("main_latency rsp_valid", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic s_do_req(input logic [2:0] addr, input logic clr, input logic [3:0] d,
                            input logic e, input logic o);
        int n = 0;
        s_req_valid = 1'b1; s_req_addr = addr; s_req_clear = clr;
        while (!s_req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL small_req_timeout: got req_ready=0 expected 1");
            s_req_valid = 1'b0; s_req_clear = 1'b0;
            return;
        end
        exp_s_q.push_back({e, o, d});
        @(posedge clk); #1;
        s_req_valid = 1'b0; s_req_clear = 1'b0;
        check("small_latency rsp_valid", {31'd0, s_rsp_valid}, 32'd1);
    endtask

    // Aligns the third high cycle of an event with the request handshake.
    task automatic sync_req(input int ch, input logic clr, input logic [15:0] d);
        @(posedge clk); #1;
        event_i[ch] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_req(3'(ch), clr, d, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        event_i[ch] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        event_i = '0; req_valid = 0; req_clear = 0; req_addr = '0; rsp_ready = 1'b1;
        s_event = '0; s_req_valid = 0; s_req_clear = 0; s_req_addr = '0; s_rsp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_data", {16'd0, rsp_data}, 32'd0);
        check("reset rsp_err/ovf", {30'd0, rsp_err, rsp_ovf}, 32'd0);
        check("reset small rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        pulse(0, 3);  do_req(3'd0, 1'b0, 16'd1, 1'b0, 1'b0);
        pulse(0, 2);  do_req(3'd0, 1'b0, 16'd1, 1'b0, 1'b0);
        pulse(0, 10); do_req(3'd0, 1'b0, 16'd2, 1'b0, 1'b0);

        repeat (5) pulse(3, 4);
        do_req(3'd3, 1'b0, 16'd5, 1'b0, 1'b0);
        do_req(3'd3, 1'b1, 16'd5, 1'b0, 1'b0);
        do_req(3'd3, 1'b0, 16'd0, 1'b0, 1'b0);

        repeat (7) pulse(2, 3);
        do_req(3'd2, 1'b0, 16'd7, 1'b0, 1'b0);
        sync_req(2, 1'b1, 16'd7);
        do_req(3'd2, 1'b0, 16'd0, 1'b0, 1'b0);

        sync_req(4, 1'b0, 16'd0);
        do_req(3'd4, 1'b0, 16'd1, 1'b0, 1'b0);

        event_i = 8'hFF;
        repeat (3) begin @(posedge clk); #1; end
        event_i = 8'h00;
        @(posedge clk); #1;
        do_req(3'd7, 1'b0, 16'd1, 1'b0, 1'b0);
        do_req(3'd4, 1'b0, 16'd2, 1'b0, 1'b0);
        do_req(3'd0, 1'b0, 16'd3, 1'b0, 1'b0);

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_req(3'd0, 1'b0, 16'd3, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall rsp_data", {16'd0, rsp_data}, 32'd3);
            check("stall req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        repeat (15) s_pulse(1, 1);
        s_do_req(3'd1, 1'b0, 4'hF, 1'b0, 1'b0);
        s_pulse(1, 1);
        s_do_req(3'd1, 1'b0, S_AFTER_WRAP, 1'b0, 1'b1);
        s_do_req(3'd1, 1'b1, S_AFTER_WRAP, 1'b0, 1'b1);
        s_do_req(3'd1, 1'b0, 4'h0, 1'b0, 1'b0);
        s_do_req(3'd6, 1'b0, 4'h0, 1'b1, 1'b0);
        s_do_req(3'd7, 1'b1, 4'h0, 1'b1, 1'b0);
        s_do_req(3'd5, 1'b0, 4'h0, 1'b0, 1'b0);

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 3'd0; req_clear = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre-reset rsp_valid", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid-reset req_ready", {31'd0, req_ready}, 32'd1);
        check("mid-reset rsp_data", {16'd0, rsp_data}, 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        do_req(3'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        repeat (3) begin @(posedge clk); #1; end
        check("main queue drained", exp_q.size(), 32'd0);
        check("small queue drained", exp_s_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++; errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
